// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/RUN/STALL sequencing, valid/ready fetch handshake and branch redirect.
// Optional saturating accepted-fetch counter on fetch_count_o, enabled by defining PC_FETCH_COUNT_EN.
module pc_fetch_unit #(
  parameter int unsigned                PC_WIDTH = 13,
  parameter logic [PC_WIDTH-1:0]        RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                fetch_valid_o,
  input  logic                fetch_ready_i,
  output logic [PC_WIDTH-1:0] fetch_pc_o,
  output logic [PC_WIDTH-1:0] pc_plus1_o,
  output logic                wrap_o
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [15:0]         fetch_count_o
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL
  } state_t;

  state_t state;
  logic   accept;

  assign pc_plus1_o = fetch_pc_o + PC_WIDTH'(1);
  assign accept     = fetch_valid_o & fetch_ready_i;

  // fetch_valid_o is registered and always equals (state == RUN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      fetch_valid_o <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state         <= stall_i ? STALL : RUN;
          fetch_valid_o <= ~stall_i;
        end
        RUN: begin
          state         <= stall_i ? STALL : RUN;
          fetch_valid_o <= ~stall_i;
        end
        STALL: begin
          state         <= stall_i ? STALL : RUN;
          fetch_valid_o <= ~stall_i;
        end
        default: begin
          state         <= BOOT;
          fetch_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Redirect wins over the increment and never flags a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_o <= RESET_PC;
      wrap_o     <= 1'b0;
    end else begin
      wrap_o <= accept & ~redirect_i & (&fetch_pc_o);
      if (redirect_i) begin
        fetch_pc_o <= redirect_pc_i;
      end else if (accept) begin
        fetch_pc_o <= pc_plus1_o;
      end
    end
  end

`ifdef PC_FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_o <= '0;
    end else if (accept && (fetch_count_o != '1)) begin
      fetch_count_o <= fetch_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus $urandom traffic against a cycle-level reference model.
// Count checks are compiled in when PC_FETCH_COUNT_EN is defined.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [12:0] redirect_pc_i = '0;
  logic        fetch_valid_o;
  logic        fetch_ready_i = 1'b0;
  logic [12:0] fetch_pc_o;
  logic [12:0] pc_plus1_o;
  logic        wrap_o;
`ifdef PC_FETCH_COUNT_EN
  logic [15:0] fetch_count_o;
`endif

  pc_fetch_unit #(.PC_WIDTH(13), .RESET_PC(13'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_pc_o    (fetch_pc_o),
    .pc_plus1_o    (pc_plus1_o),
    .wrap_o        (wrap_o)
`ifdef PC_FETCH_COUNT_EN
    ,
    .fetch_count_o (fetch_count_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: PC as a plain integer modulo 2^13.
  int m_pc    = 0;
  int m_valid = 0;
  int m_wrap  = 0;
  int m_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_pc"},    32'(fetch_pc_o),    32'(m_pc));
    check({pfx, "_valid"}, 32'(fetch_valid_o), 32'(m_valid));
    check({pfx, "_wrap"},  32'(wrap_o),        32'(m_wrap));
`ifdef PC_FETCH_COUNT_EN
    check({pfx, "_count"}, 32'(fetch_count_o), 32'(m_count));
`endif
  endtask

  // Called at posedge+1: drive inputs, check pc_plus1 before the edge, then advance one cycle.
  task automatic step(input bit stall, input bit redir, input int rpc, input bit ready);
    bit acc;
    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = 13'(rpc);
    fetch_ready_i = ready;
    #1;
    check("plus1", 32'(pc_plus1_o), 32'((m_pc + 1) % 8192));
    acc = (m_valid != 0) && ready;
    @(posedge clk);
    #1;
    m_wrap = (acc && !redir && m_pc == 8191) ? 1 : 0;
    if (redir)    m_pc = rpc % 8192;
    else if (acc) m_pc = (m_pc + 1) % 8192;
    if (acc && m_count < 65535) m_count++;
    m_valid = stall ? 0 : 1;
    check_all("cyc");
  endtask

  // Asserts reset between edges (mid-handshake if valid is up) and checks it takes effect at once.
  task automatic do_reset();
    fetch_ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    m_pc = 0; m_valid = 0; m_wrap = 0; m_count = 0;
    check_all("rst");
    stall_i = 1'b0; redirect_i = 1'b0; fetch_ready_i = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Valid rises one cycle after release, then 0,1,2,3 back to back.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      check("boot_seq_pc", 32'(fetch_pc_o), 32'(i));
      check("boot_seq_valid", 32'(fetch_valid_o), 32'd1);
    end

    // Backpressure holds the PC.
    step(0, 1, 13'h0005, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("hold_pc", 32'(fetch_pc_o), 32'h5);
    end
    step(0, 0, 0, 1);
    check("hold_release_pc", 32'(fetch_pc_o), 32'h6);

    // Wrap from all-ones.
    step(0, 1, 13'h1FFF, 0);
    check("wrap_plus1", 32'(pc_plus1_o), 32'h0);
    step(0, 0, 0, 1);
    check("wrap_pc", 32'(fetch_pc_o), 32'h0);
    check("wrap_pulse", 32'(wrap_o), 32'd1);
    step(0, 0, 0, 0);
    check("wrap_drop", 32'(wrap_o), 32'd0);

    // Redirect with an accepted fetch goes to the target.
    step(0, 1, 13'h0010, 0);
    step(0, 1, 13'h0A00, 1);
    check("redir_acc_pc", 32'(fetch_pc_o), 32'hA00);
    check("redir_acc_wrap", 32'(wrap_o), 32'd0);

    // Stall for four cycles with a redirect in the second.
    step(1, 0, 0, 1);
    step(1, 1, 13'h0100, 1);
    check("stall_valid", 32'(fetch_valid_o), 32'd0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("stall_pc", 32'(fetch_pc_o), 32'h100);
    step(0, 0, 0, 1);
    check("stall_exit_pc", 32'(fetch_pc_o), 32'h100);
    check("stall_exit_valid", 32'(fetch_valid_o), 32'd1);

    // Redirect of an all-ones PC must not pulse wrap.
    step(0, 1, 13'h1FFF, 0);
    step(0, 1, 13'h0003, 1);
    check("redir_nowrap", 32'(wrap_o), 32'd0);

    // Randomized traffic, including stalls, redirects near the wrap point and a reset.
    for (int i = 0; i < 600; i++) begin
      bit st, rd, rdy;
      int tgt;
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = ($urandom_range(0, 1) == 0) ? int'($urandom_range(8188, 8191)) : int'($urandom_range(0, 8191));
      if (i == 300) begin
        do_reset();
      end
      step(st, rd, tgt, rdy);
    end

`ifdef PC_FETCH_COUNT_EN
    do_reset();
    for (int i = 0; i < 65541; i++) begin
      step(0, 0, 0, 1);
    end
    check("count_sat", 32'(fetch_count_o), 32'hFFFF);
    do_reset();
    check("count_rst", 32'(fetch_count_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: PC_WIDTH, default 13, width of every PC-valued port and register.
REQ-002 Parameter: RESET_PC, default 13'h0000, PC value loaded on reset.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: stall_i  input  1  hazard stall; holds the PC and suppresses the fetch request.
REQ-006 Port: redirect_i  input  1  branch/jump taken; loads redirect_pc_i.
REQ-007 Port: redirect_pc_i  input  PC_WIDTH  branch/jump target.
REQ-008 Port: fetch_valid_o  output  1  fetch request to instruction memory is valid.
REQ-009 Port: fetch_ready_i  input  1  instruction memory accepts the request.
REQ-010 Port: fetch_pc_o  output  PC_WIDTH  current PC, the address of the outstanding request.
REQ-011 Port: pc_plus1_o  output  PC_WIDTH  combinational fetch_pc_o + 1, modulo 2^PC_WIDTH.
REQ-012 Port: wrap_o  output  1  one-cycle pulse when the PC wraps from all-ones to zero.

Function
REQ-013 The block SHALL implement the states BOOT, RUN and STALL.
REQ-014 BOOT: fetch_valid_o=0; the block SHALL go to RUN on the next edge if stall_i=0, otherwise to STALL.
REQ-015 RUN: fetch_valid_o=1; stall_i=1 SHALL move the block to STALL on the next edge.
REQ-016 STALL: fetch_valid_o=0 and the PC held; stall_i=0 SHALL return the block to RUN on the next edge.
REQ-017 Handshake: a fetch is accepted in any cycle where fetch_valid_o=1 and fetch_ready_i=1.
REQ-018 An accepted fetch with redirect_i=0 SHALL load PC <= pc_plus1_o on that edge; PC advances by one per accepted fetch (single-cycle throughput).
REQ-019 While fetch_valid_o=1 and fetch_ready_i=0 with redirect_i=0, fetch_pc_o SHALL remain stable.
REQ-020 redirect_i=1 SHALL load PC <= redirect_pc_i on the next edge in every state, including BOOT and STALL, and SHALL take priority over the increment.
REQ-021 Redirect with a simultaneous accepted fetch: the old-PC fetch counts as accepted; the next PC is the target, not PC+1.
REQ-022 Redirect with an unaccepted request SHALL withdraw that request; this is the only case where fetch_pc_o may change while valid is high.
REQ-023 Redirect with stall_i=1 in RUN: the PC loads the target and the state moves to STALL.
REQ-024 Wrap: an accepted increment from all-ones SHALL yield 0 and pulse wrap_o high for exactly the following cycle; redirects never assert wrap_o.
REQ-025 pc_plus1_o SHALL be PC_WIDTH bits, with the carry out discarded.

Reset
REQ-026 rst_n=0 SHALL immediately force state=BOOT, PC=RESET_PC, fetch_valid_o=0, wrap_o=0 and (if enabled) fetch_count_o=0, regardless of clk.
REQ-027 Reset asserted mid-handshake SHALL drop fetch_valid_o immediately; the pending request is abandoned.
REQ-028 After rst_n deasserts, the first request SHALL appear one cycle later (BOOT lasts exactly one cycle).

Configuration
REQ-029 Macro PC_FETCH_COUNT_EN: when defined, the block SHALL add the output fetch_count_o (16 bits), which counts accepted fetches, saturates at 16'hFFFF and resets to 0.
REQ-030 When PC_FETCH_COUNT_EN is not defined, fetch_count_o and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Reset release with fetch_ready_i=1 held -> valid rises one cycle after release; fetch_pc_o reads 0,1,2,3 on consecutive cycles.
REQ-032 PC=13'h0005 with fetch_ready_i=0 for 3 cycles, then 1 -> fetch_pc_o stays 5 for 3 cycles, then 6.
REQ-033 PC=13'h1FFF with an accepted fetch -> PC becomes 13'h0000 and wrap_o pulses for one cycle; pc_plus1_o showed 13'h0000 beforehand.
REQ-034 PC=13'h0010 with redirect_i=1, redirect_pc_i=13'h0A00 and an accepted fetch -> next PC is 13'h0A00, not 13'h0011; fetch_count_o increments by 1.
REQ-035 stall_i=1 for 4 cycles with a redirect to 13'h0100 in cycle 2 -> valid low throughout; after the stall ends, the first request is 13'h0100.
REQ-036 PC_FETCH_COUNT_EN defined, 65540 accepted fetches -> fetch_count_o=16'hFFFF; rst_n=0 mid-handshake -> count 0 and valid 0 immediately.
